muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the MIPS core; owns the HI/LO registers.
- Borrows a dedicated 32-bit ALU instance for the per-step add (multiply) or subtract (divide) and sequences it over 32 iterations.
- Supported operations: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits beside the execute stage. The pipeline stalls on busy for MFHI/MFLO and for a new mul/div.

Parameters:
- ALU_ADD, 11'b00000000001, one-hot ALU opcode driven for an add step.
- ALU_SUB, 11'b00000100000, one-hot ALU opcode driven for a subtract step.
- DIV0_LO, 32'hFFFFFFFF, LO result on divide by zero.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  launch an operation; accepted only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- rs  in  32  multiplicand / dividend; sampled with start
- rt  in  32  multiplier / divisor; sampled with start
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; HI/LO valid in the same cycle
- hi  out  32  HI register
- lo  out  32  LO register
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  11  ALU opcode; 0 outside ITER
- alu_sa  out  5  always 0
- alu_out  in  32  combinational ALU result; same cycle

Behaviour:
- Reset (highest priority, any state): state=IDLE; busy=0; done=0; hi=0; lo=0; iteration counter=0; alu_a=alu_b=0; alu_op=0.
- States and transitions:
  - IDLE -> PREP when start=1.
  - PREP (1 cycle) -> ITER.
  - ITER (32 cycles, counter 0..31) -> FIX.
  - FIX (1 cycle) -> IDLE, with done=1 in that cycle.
- Timing:
  - start accepted at edge N; busy=1 for edges N+1..N+34.
  - done and new hi/lo visible after edge N+34.
  - Fixed latency of 34 cycles for every op, including divide by zero.
- PREP:
  - Signed ops (MULT, DIV): compute |rs| and |rt| locally (two's complement negate; no ALU use). Record sign flags: quotient/product sign = rs[31]^rt[31]; remainder sign = rs[31].
  - Unsigned ops: use operands as-is.
- Multiply (shift-add), per ITER cycle:
  - Drive alu_a=P_hi, alu_b=M, alu_op = ALU_ADD if P_lo[0] else 0.
  - carry = (alu_out < P_hi), unsigned, computed locally.
  - Next {c,P_hi,P_lo} = {carry or 0, sum or P_hi, P_lo} >> 1.
  - P_lo is initialised to the multiplier.
- Divide (restoring), per ITER cycle:
  - Shift {R, Q} left by 1.
  - Drive alu_a = shifted R, alu_b = D, alu_op = ALU_SUB.
  - If the shifted-out bit is 1, or shifted R >= D unsigned: R = alu_out and Q[0] = 1.
- FIX:
  - MULT: if the sign flag is set, negate the 64-bit product.
  - DIV: negate Q if the quotient sign is set; negate R if the remainder sign is set.
  - Write HI/LO: product {HI,LO}; divide HI=R, LO=Q.
- Special cases (override in FIX):
  - rt=0 on DIV/DIVU: HI = rs (original, unmodified), LO = DIV0_LO.
  - DIV with rs=32'h80000000 and rt=32'hFFFFFFFF: HI=0, LO=32'h80000000.
- start while busy: ignored; no queueing.
- mthi/mtlo:
  - In IDLE: register written at the next edge.
  - While busy: ignored.
  - Same cycle as an accepted start: the write takes effect, and FIX later overwrites it.
  - mthi and mtlo together: both written.
- Reset mid-operation: abort immediately; no done pulse; HI/LO cleared.

Test Plan:
- Reset, then MULTU rs=32'hFFFFFFFF rt=32'hFFFFFFFF -> done exactly 34 cycles after start; hi=32'hFFFFFFFE, lo=32'h00000001; busy high for 34 cycles.
- MULT rs=-7 (32'hFFFFFFF9) rt=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6; then DIVU rs=100 rt=7 -> hi=2, lo=14.
- DIV rs=-7 rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Separately, DIV rs=32'h80000000 rt=32'hFFFFFFFF -> hi=0, lo=32'h80000000.
- DIVU rs=1234 rt=0 -> hi=1234, lo=32'hFFFFFFFF after 34 cycles. Check alu_op is 0 in IDLE and PREP, and is ALU_SUB for every ITER cycle.
- Second start and an mthi pulse asserted at cycle 10 of a busy MULTU -> both ignored; result unchanged; exactly one done. MTLO wdata=32'hA5A5A5A5 in IDLE -> lo=32'hA5A5A5A5 next cycle.
- reset asserted at ITER cycle 15 -> next cycle busy=0, hi=lo=0, no done. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Function : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, using an
//            external ALU for the per-step add/subtract.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_sequencer #(
    parameter logic [10:0] ALU_ADD = 11'b00000000001,
    parameter logic [10:0] ALU_SUB = 11'b00000100000,
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [10:0] alu_op,
    output logic [4:0]  alu_sa,
    input  logic [31:0] alu_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  r_state, w_next;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_hi, r_lo;
    logic [1:0]  r_op;
    logic [31:0] r_rs, r_rt;
    logic [31:0] r_ph, r_pl, r_m;   // product hi/lo, or remainder/quotient; multiplicand or divisor

    logic        w_div, w_signed;
    logic [31:0] w_abs_rs, w_abs_rt;
    logic        w_carry, w_take;
    logic [31:0] w_r_sh;
    logic [63:0] w_prod, w_prod_fix;
    logic [31:0] w_q_fix, w_r_fix;
    logic [31:0] w_fix_hi, w_fix_lo;

    assign w_div    = r_op[1];
    assign w_signed = r_op[0];
    assign w_abs_rs = (w_signed && r_rs[31]) ? (~r_rs + 32'd1) : r_rs;
    assign w_abs_rt = (w_signed && r_rt[31]) ? (~r_rt + 32'd1) : r_rt;

    assign w_carry = (alu_out < r_ph);
    assign w_r_sh  = {r_ph[30:0], r_pl[31]};
    assign w_take  = r_ph[31] | (w_r_sh >= r_m);

    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = (w_signed && (r_rs[31] ^ r_rt[31])) ? (~w_prod + 64'd1) : w_prod;
    assign w_q_fix    = (w_signed && (r_rs[31] ^ r_rt[31])) ? (~r_pl + 32'd1) : r_pl;
    assign w_r_fix    = (w_signed && r_rs[31]) ? (~r_ph + 32'd1) : r_ph;

    always_comb begin
        w_fix_hi = w_prod_fix[63:32];
        w_fix_lo = w_prod_fix[31:0];
        if (w_div) begin
            w_fix_hi = w_r_fix;
            w_fix_lo = w_q_fix;
            if (r_rt == 32'd0) begin
                w_fix_hi = r_rs;
                w_fix_lo = DIV0_LO;
            end else if (w_signed && (r_rs == 32'h80000000) && (r_rt == 32'hFFFFFFFF)) begin
                w_fix_hi = 32'd0;
                w_fix_lo = 32'h80000000;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PREP;
            S_PREP:  w_next = S_ITER;
            S_ITER:  if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 5'd0;
            r_done <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_op   <= 2'd0;
            r_rs   <= 32'd0;
            r_rt   <= 32'd0;
            r_ph   <= 32'd0;
            r_pl   <= 32'd0;
            r_m    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_op <= op;
                        r_rs <= rs;
                        r_rt <= rt;
                    end
                end
                S_PREP: begin
                    r_ph  <= 32'd0;
                    r_cnt <= 5'd0;
                    if (w_div) begin
                        r_pl <= w_abs_rs;
                        r_m  <= w_abs_rt;
                    end else begin
                        r_pl <= w_abs_rt;
                        r_m  <= w_abs_rs;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_div) begin
                        r_ph <= w_take ? alu_out : w_r_sh;
                        r_pl <= {r_pl[30:0], w_take};
                    end else if (r_pl[0]) begin
                        r_ph <= {w_carry, alu_out[31:1]};
                        r_pl <= {alu_out[0], r_pl[31:1]};
                    end else begin
                        r_ph <= {1'b0, r_ph[31:1]};
                        r_pl <= {r_ph[0], r_pl[31:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    // ALU is only borrowed during ITER; quiet it otherwise
    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = 11'd0;
        if (r_state == S_ITER) begin
            alu_b = r_m;
            if (w_div) begin
                alu_a  = w_r_sh;
                alu_op = ALU_SUB;
            end else begin
                alu_a  = r_ph;
                alu_op = r_pl[0] ? ALU_ADD : 11'd0;
            end
        end
    end

    assign alu_sa = 5'd0;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Function : Directed self-checking bench for muldiv_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_sequencer;

    localparam logic [10:0] C_ALU_ADD = 11'b00000000001;
    localparam logic [10:0] C_ALU_SUB = 11'b00000100000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = 32'd0, rt = 32'd0, wdata = 32'd0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo, alu_a, alu_b, alu_out;
    logic [10:0] alu_op;
    logic [4:0]  alu_sa;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_sa(alu_sa), .alu_out(alu_out)
    );

    // Reference ALU shared by the core
    always_comb begin
        case (alu_op)
            C_ALU_ADD: alu_out = alu_a + alu_b;
            C_ALU_SUB: alu_out = alu_a - alu_b;
            default:   alu_out = 32'd0;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int lat, bcnt, dcnt;
    logic [31:0] got_hi, got_lo, start_hi;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op and watch 40 cycles; inj>0 pokes a start+mthi at that cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
        start = 1'b1; op = o; rs = a; rt = b;
        tick();
        start = 1'b0; rs = 32'd0; rt = 32'd0; mthi = 1'b0; mtlo = 1'b0;
        start_hi = hi;
        lat = 0; dcnt = 0; bcnt = busy ? 1 : 0;
        got_hi = 32'hX; got_lo = 32'hX;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj) begin
                start = 1'b1; op = 2'b11; rs = 32'h55; rt = 32'h3;
                mthi = 1'b1; wdata = 32'hDEADBEEF;
            end
            tick();
            if (k == inj) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = k; got_hi = hi; got_lo = lo;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 32'd0)     begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0)     begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (alu_op !== 11'd0) begin bad++; $display("FAIL reset_aluop got=%h exp=0", alu_op); end
        total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL reset_aluab got=%h/%h exp=0/0", alu_a, alu_b); end
        total++; if (alu_sa !== 5'd0)  begin bad++; $display("FAIL reset_alusa got=%h exp=0", alu_sa); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu();
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        total++; if (lat !== 34)  begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        total++; if (bcnt !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=34", bcnt); end
        total++; if (dcnt !== 1)  begin bad++; $display("FAIL multu_done_count got=%0d exp=1", dcnt); end
        total++; if (got_hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", got_hi); end
        total++; if (got_lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", got_lo); end
        run_op(2'b00, 32'h12345678, 32'h00000010, 0);
        total++; if (got_hi !== 32'h1 || got_lo !== 32'h23456780) begin bad++; $display("FAIL multu_shift got=%h_%h exp=00000001_23456780", got_hi, got_lo); end
    endtask

    task automatic test_mult();
        run_op(2'b01, 32'hFFFFFFF9, 32'd6, 0);
        total++; if (got_hi !== 32'hFFFFFFFF || got_lo !== 32'hFFFFFFD6) begin bad++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffd6", got_hi, got_lo); end
        run_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFFC, 0);
        total++; if (got_hi !== 32'd0 || got_lo !== 32'd12) begin bad++; $display("FAIL mult_negneg got=%h_%h exp=00000000_0000000c", got_hi, got_lo); end
    endtask

    task automatic test_div();
        run_op(2'b10, 32'd100, 32'd7, 0);
        total++; if (got_hi !== 32'd2 || got_lo !== 32'd14) begin bad++; $display("FAIL divu got=%h/%h exp=2/e", got_hi, got_lo); end
        total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        total++; if (got_hi !== 32'hFFFFFFFF || got_lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_negdividend got=%h/%h exp=ffffffff/fffffffd", got_hi, got_lo); end
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, 0);
        total++; if (got_hi !== 32'd1 || got_lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_negdivisor got=%h/%h exp=1/fffffffd", got_hi, got_lo); end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        total++; if (got_hi !== 32'd0 || got_lo !== 32'h80000000) begin bad++; $display("FAIL div_overflow got=%h/%h exp=0/80000000", got_hi, got_lo); end
    endtask

    task automatic test_div_by_zero();
        logic [10:0] exp_op;
        total++; if (alu_op !== 11'd0) begin bad++; $display("FAIL dbz_aluop_idle got=%h exp=0", alu_op); end
        start = 1'b1; op = 2'b10; rs = 32'd1234; rt = 32'd0;
        tick();
        start = 1'b0; rs = 32'd0;
        lat = 0; got_hi = 32'hX; got_lo = 32'hX;
        for (int k = 0; k <= 36; k++) begin
            exp_op = (k >= 1 && k <= 32) ? C_ALU_SUB : 11'd0;
            total++; if (alu_op !== exp_op) begin bad++; $display("FAIL dbz_aluop cycle=%0d got=%h exp=%h", k, alu_op, exp_op); end
            if (done && lat == 0) begin lat = k; got_hi = hi; got_lo = lo; end
            tick();
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL dbz_latency got=%0d exp=34", lat); end
        total++; if (got_hi !== 32'd1234 || got_lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_divu got=%h/%h exp=4d2/ffffffff", got_hi, got_lo); end
        run_op(2'b11, 32'hFFFFFFFB, 32'd0, 0);
        total++; if (got_hi !== 32'hFFFFFFFB || got_lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_div got=%h/%h exp=fffffffb/ffffffff", got_hi, got_lo); end
    endtask

    task automatic test_busy_ignore();
        run_op(2'b00, 32'd3, 32'd5, 10);
        total++; if (dcnt !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", dcnt); end
        total++; if (lat !== 34) begin bad++; $display("FAIL busy_latency got=%0d exp=34", lat); end
        total++; if (got_hi !== 32'd0 || got_lo !== 32'd15) begin bad++; $display("FAIL busy_result got=%h/%h exp=0/f", got_hi, got_lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL busy_mthi_ignored got=%h exp=0", hi); end
    endtask

    task automatic test_mtlo_mthi();
        mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        tick();
        mtlo = 1'b0;
        total++; if (lo !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtlo got=%h exp=a5a5a5a5", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=0", hi); end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h12345678 || lo !== 32'h12345678) begin bad++; $display("FAIL mthi_mtlo got=%h/%h exp=12345678/12345678", hi, lo); end
        mthi = 1'b1; wdata = 32'hCAFEF00D;
        run_op(2'b00, 32'd3, 32'd5, 0);
        total++; if (start_hi !== 32'hCAFEF00D) begin bad++; $display("FAIL mthi_with_start got=%h exp=cafef00d", start_hi); end
        total++; if (got_hi !== 32'd0 || got_lo !== 32'd15) begin bad++; $display("FAIL mthi_overwritten got=%h/%h exp=0/f", got_hi, got_lo); end
    endtask

    task automatic test_reset_mid_op();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h11111111;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; op = 2'b00; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        repeat (16) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) dcnt++;
            tick();
        end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", dcnt); end
        run_op(2'b10, 32'd100, 32'd7, 0);
        total++; if (lat !== 34 || got_hi !== 32'd2 || got_lo !== 32'd14) begin bad++; $display("FAIL midreset_restart got=lat%0d %h/%h exp=lat34 2/e", lat, got_hi, got_lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_busy_ignore();
        test_mtlo_mthi();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
